// File: rtl/game_cmd_pkg.sv
// game_cmd_pkg: shared command enum, ASCII codes and byte decoder.
package game_cmd_pkg;
   typedef enum logic [1:0] {CMD_FLAP, CMD_START, CMD_PAUSE, CMD_RESTART} cmd_t;
   typedef struct packed {
      logic legal;
      cmd_t cmd;
   } dec_t;
   localparam logic [7:0] ASC_F     = 8'h46;
   localparam logic [7:0] ASC_F_LC  = 8'h66;
   localparam logic [7:0] ASC_SPACE = 8'h20;
   localparam logic [7:0] ASC_S     = 8'h53;
   localparam logic [7:0] ASC_S_LC  = 8'h73;
   localparam logic [7:0] ASC_P     = 8'h50;
   localparam logic [7:0] ASC_P_LC  = 8'h70;
   localparam logic [7:0] ASC_R     = 8'h52;
   localparam logic [7:0] ASC_R_LC  = 8'h72;

   function automatic dec_t decode(input logic [7:0] b);
      dec_t d;
      logic is_f, is_s, is_p, is_r;
      is_f = b == ASC_F || b == ASC_F_LC || b == ASC_SPACE;
      is_s = b == ASC_S || b == ASC_S_LC;
      is_p = b == ASC_P || b == ASC_P_LC;
      is_r = b == ASC_R || b == ASC_R_LC;
      d.legal = is_f || is_s || is_p || is_r;
      d.cmd = is_f ? CMD_FLAP : is_s ? CMD_START : is_p ? CMD_PAUSE : CMD_RESTART;
      return d;
   endfunction
endpackage

// File: rtl/uart_cmd_decode_if.sv
// uart_cmd_decode_if: UART byte input, vsync and command/status outputs.
interface uart_cmd_decode_if;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       vs_in;
   logic       cmd_flap;
   logic       cmd_start;
   logic       cmd_restart;
   logic       paused;
   logic       ovf;
   logic [7:0] drop_cnt;
   modport master (output rx_data, rx_data_valid, vs_in,
                   input cmd_flap, cmd_start, cmd_restart, paused, ovf, drop_cnt);
   modport slave (input rx_data, rx_data_valid, vs_in,
                  output cmd_flap, cmd_start, cmd_restart, paused, ovf, drop_cnt);
endinterface

// File: rtl/cmd_fifo.sv
// cmd_fifo: command queue; pointers carry one extra bit to tell full from empty.
module cmd_fifo
   import game_cmd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  cmd_t din,
   output cmd_t dout,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   cmd_t mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   assign empty = wr_ptr == rd_ptr;
   assign full  = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
   assign dout  = mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/uart_cmd_decode.sv
// uart_cmd_decode: UART command bytes queued and released one per video frame start.
// Optional CMD_DROP_STATS_EN build adds the saturating drop_cnt counter.
module uart_cmd_decode
   import game_cmd_pkg::*;
#(
   parameter int   DEPTH  = 4,
   parameter logic VS_POL = 1'b0
) (
   input logic               clk,
   input logic               rst_n,
   uart_cmd_decode_if.slave  bus
);
   logic vs_s1, vs_s2, vs_s3;
   logic full, empty, frame_edge, pop, push, drop_full;
   logic flap_q, start_q, restart_q, paused_q, ovf_q;
   logic flap_d, start_d, restart_d, paused_d, ovf_d;
   dec_t dec;
   cmd_t head;
   assign dec        = decode(bus.rx_data);
   assign frame_edge = vs_s2 == VS_POL && vs_s3 != VS_POL;
   assign pop        = frame_edge && !empty;
   // a pop in the same cycle frees the slot, so a push into a full queue is still accepted
   assign push       = bus.rx_data_valid && dec.legal && (!full || pop);
   assign drop_full  = bus.rx_data_valid && dec.legal && full && !pop;
   cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
      .din(dec.cmd), .dout(head), .full(full), .empty(empty)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {vs_s1, vs_s2, vs_s3} <= {3{~VS_POL}};
      else {vs_s1, vs_s2, vs_s3} <= {bus.vs_in, vs_s1, vs_s2};
   always_comb begin
      flap_d    = pop && head == CMD_FLAP && !paused_q;
      start_d   = pop && head == CMD_START;
      restart_d = pop && head == CMD_RESTART;
      paused_d  = !pop ? paused_q : head == CMD_PAUSE ? !paused_q :
                  (start_d || restart_d) ? 1'b0 : paused_q;
      ovf_d     = drop_full ? 1'b1 : restart_d ? 1'b0 : ovf_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {flap_q, start_q, restart_q, paused_q, ovf_q} <= '0;
      else {flap_q, start_q, restart_q, paused_q, ovf_q} <= {flap_d, start_d, restart_d, paused_d, ovf_d};
   assign bus.cmd_flap    = flap_q;
   assign bus.cmd_start   = start_q;
   assign bus.cmd_restart = restart_q;
   assign bus.paused      = paused_q;
   assign bus.ovf         = ovf_q;
`ifdef CMD_DROP_STATS_EN
   logic [7:0] drop_cnt;
   logic       drop;
   assign drop = (bus.rx_data_valid && !dec.legal) || drop_full;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) drop_cnt <= '0;
      else if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 1'b1;
   assign bus.drop_cnt = drop_cnt;
`else
   assign bus.drop_cnt = '0;
`endif
endmodule

// File: tb/tb_uart_cmd_decode.sv
// tb_uart_cmd_decode: directed stimulus with a queue-based reference model of the command path.
module tb_uart_cmd_decode;
   import game_cmd_pkg::*;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0] pulses;
   int checks = 0;
   int errors = 0;
   cmd_t q[$];
   bit m_paused, m_ovf;
   int m_drops;

   uart_cmd_decode_if bus();
   uart_cmd_decode #(.DEPTH(DEPTH), .VS_POL(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #10 clk = ~clk;
   assign pulses = {bus.cmd_flap, bus.cmd_start, bus.cmd_restart};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_decode(input logic [7:0] b, output cmd_t c);
      c = CMD_FLAP;
      case (b)
         8'h46, 8'h66, 8'h20: begin c = CMD_FLAP; return 1'b1; end
         8'h53, 8'h73: begin c = CMD_START; return 1'b1; end
         8'h50, 8'h70: begin c = CMD_PAUSE; return 1'b1; end
         8'h52, 8'h72: begin c = CMD_RESTART; return 1'b1; end
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] exp_drop();
`ifdef CMD_DROP_STATS_EN
      return (m_drops > 255) ? 32'd255 : 32'(m_drops);
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_push(input logic [7:0] b);
      cmd_t c;
      if (!m_decode(b, c)) m_drops++;
      else if (q.size() < DEPTH) q.push_back(c);
      else begin
         m_ovf = 1'b1;
         m_drops++;
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data = b;
      bus.rx_data_valid = 1'b1;
      model_push(b);
      @(negedge clk);
      bus.rx_data_valid = 1'b0;
   endtask

   // one frame-start edge; optionally injects a byte so it lands on the pop edge
   task automatic frame(input string tag, input bit inj, input logic [7:0] b);
      logic [2:0] exp;
      cmd_t c;
      exp = 3'b000;
      if (q.size() > 0) begin
         c = q.pop_front();
         case (c)
            CMD_FLAP: if (!m_paused) exp = 3'b100;
            CMD_START: begin exp = 3'b010; m_paused = 1'b0; end
            CMD_PAUSE: m_paused = !m_paused;
            CMD_RESTART: begin exp = 3'b001; m_paused = 1'b0; m_ovf = 1'b0; end
         endcase
      end
      @(negedge clk);
      bus.vs_in = 1'b0;
      @(negedge clk);
      chk({tag, "_edge1"}, 32'(pulses), 32'd0);
      @(negedge clk);
      chk({tag, "_edge2"}, 32'(pulses), 32'd0);
      if (inj) begin
         bus.rx_data = b;
         bus.rx_data_valid = 1'b1;
         model_push(b);
      end
      @(negedge clk);
      bus.rx_data_valid = 1'b0;
      chk({tag, "_pulse"}, 32'(pulses), 32'(exp));
      chk({tag, "_paused"}, 32'(bus.paused), 32'(m_paused));
      chk({tag, "_ovf"}, 32'(bus.ovf), 32'(m_ovf));
      @(negedge clk);
      chk({tag, "_edge4"}, 32'(pulses), 32'd0);
      bus.vs_in = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic model_reset();
      q.delete();
      m_paused = 1'b0;
      m_ovf = 1'b0;
      m_drops = 0;
   endtask

   initial begin
      bus.rx_data = 8'h00;
      bus.rx_data_valid = 1'b0;
      bus.vs_in = 1'b1;
      model_reset();
      #5;
      chk("reset_outputs", 32'({pulses, bus.paused, bus.ovf, bus.drop_cnt}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("release_no_pulse", 32'(pulses), 32'd0);
      send("f");
      frame("single_flap", 1'b0, 8'h00);
      frame("second_edge_idle", 1'b0, 8'h00);
      send("S"); send("F"); send("F");
      frame("sff_start", 1'b0, 8'h00);
      frame("sff_flap1", 1'b0, 8'h00);
      frame("sff_flap2", 1'b0, 8'h00);
      send("P"); send("F"); send("P"); send("F");
      frame("pause_on", 1'b0, 8'h00);
      frame("flap_while_paused", 1'b0, 8'h00);
      frame("pause_off", 1'b0, 8'h00);
      frame("flap_unpaused", 1'b0, 8'h00);
      send("f"); send("s"); send(8'h20); send("S"); send("F"); send("F");
      chk("overflow_set", 32'(bus.ovf), 32'd1);
      chk("overflow_drops", 32'(bus.drop_cnt), exp_drop());
      for (int i = 0; i < 5; i++) frame($sformatf("drain_full_%0d", i), 1'b0, 8'h00);
      send("r");
      frame("restart_clears_ovf", 1'b0, 8'h00);
      send("F"); send("F"); send("F"); send("F");
      chk("full_no_ovf", 32'(bus.ovf), 32'd0);
      frame("coincident_push_pop", 1'b1, "S");
      chk("coincident_ovf", 32'(bus.ovf), 32'd0);
      for (int i = 0; i < 5; i++) frame($sformatf("drain_coinc_%0d", i), 1'b0, 8'h00);
      send("x"); send(8'h00);
      chk("illegal_drops", 32'(bus.drop_cnt), exp_drop());
      frame("illegal_not_queued", 1'b0, 8'h00);
      send("F"); send("S");
      @(negedge clk);
      #3 rst_n = 1'b0;
      model_reset();
      #1 chk("midrun_reset_outputs", 32'({pulses, bus.paused, bus.ovf, bus.drop_cnt}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrun_release_no_pulse", 32'(pulses), 32'd0);
      frame("queue_lost_on_reset", 1'b0, 8'h00);
      chk("drop_cleared_by_reset", 32'(bus.drop_cnt), exp_drop());
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_cmd_decode.md
UART_CMD_DECODE -- requirements
Module: uart_cmd_decode

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter VS_POL, default 1'b0, meaning active level of vs_in; the frame-start edge is the transition into this level.
REQ-003 SHALL have port clk, input, 1, single system clock (50 MHz).
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port rx_data, input, 8, received UART byte.
REQ-006 SHALL have port rx_data_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port vs_in, input, 1, video vertical sync from the pixel-clock domain (asynchronous to clk).
REQ-008 SHALL have ports cmd_flap, cmd_start, cmd_restart, outputs, 1 each, one-cycle command pulses.
REQ-009 SHALL have port paused, output, 1, pause level.
REQ-010 SHALL have ports ovf (output, 1, sticky overflow) and drop_cnt (output, 8, dropped-byte count).

Function
REQ-011 SHALL decode bytes: 'F', 'f', 0x20 -> FLAP; 'S', 's' -> START; 'P', 'p' -> PAUSE; 'R', 'r' -> RESTART; any other byte -> illegal, dropped.
REQ-012 SHALL push a legal command into the FIFO on the clk edge where rx_data_valid=1 and the FIFO is not full.
REQ-013 SHALL drop a legal command arriving while full, and SHALL set ovf.
REQ-014 SHALL synchronise vs_in through two flops and detect the frame-start edge by comparing sync stage 2 with a third registered copy.
REQ-015 SHALL pop at most one entry per frame-start edge; pulse outputs SHALL be registered and high for exactly one clk, 3 clk edges after vs_in first meets setup.
REQ-016 SHALL pulse cmd_flap on a popped FLAP only when paused=0; a FLAP popped while paused SHALL be discarded with no pulse.
REQ-017 SHALL toggle paused on a popped PAUSE, with no pulse output.
REQ-018 SHALL pulse cmd_start on a popped START, pulse cmd_restart on a popped RESTART, and clear paused on either.
REQ-019 SHALL clear ovf on a popped RESTART.
REQ-020 SHALL, on a simultaneous push and pop while full, accept the push without setting ovf.
REQ-021 SHALL do nothing on a frame-start edge with an empty FIFO, leaving all pulses at 0.
REQ-022 SHALL assert at most one of cmd_flap, cmd_start, cmd_restart in any cycle.
REQ-023 SHALL wrap the FIFO pointers modulo DEPTH, using an extra pointer bit to distinguish full from empty.

Reset
REQ-024 SHALL, while rst_n=0, hold all pulses, paused, ovf and drop_cnt at 0, empty the FIFO, and preset the sync flops to the inactive VS_POL level.
REQ-025 SHALL lose any queued commands on reset asserted mid-operation, and SHALL emit no pulse in the first cycle after release.

Configuration
REQ-026 SHALL, with CMD_DROP_STATS_EN defined, increment drop_cnt (saturating at 255) for each illegal byte and each byte dropped while full.
REQ-027 SHALL, with CMD_DROP_STATS_EN defined, clear drop_cnt only on reset.
REQ-028 SHALL, with CMD_DROP_STATS_EN undefined, tie drop_cnt to 0 with no counter logic; ovf SHALL behave identically in both builds.

Structure
REQ-029 SHALL take from shared package game_cmd_pkg: enum cmd_t {CMD_FLAP, CMD_START, CMD_PAUSE, CMD_RESTART} and the ASCII code constants.
REQ-030 SHALL place FIFO storage and pointers in sub-module cmd_fifo (push, pop, din, dout, full, empty).
REQ-031 SHALL keep decode, the vs synchroniser and the pause/pulse logic in uart_cmd_decode.

Verification
REQ-032 SHALL verify: byte 'f' then one vs_in edge -> exactly one cmd_flap pulse; a second edge -> no pulse.
REQ-033 SHALL verify: "SFF" sent within one frame -> cmd_start, cmd_flap, cmd_flap on three successive frame edges.
REQ-034 SHALL verify: 'P', 'F', 'P', 'F' -> paused goes 1, first FLAP produces no pulse, paused goes 0, second FLAP pulses.
REQ-035 SHALL verify: 6 legal bytes with DEPTH=4 and no vs -> ovf=1, only 4 commands drained; drop_cnt=2 with macro, 0 without.
REQ-036 SHALL verify: full FIFO, push coincident with a frame-edge pop -> ovf stays 0 and the pushed command drains last.
REQ-037 SHALL verify: bytes 'x', 0x00 -> no FIFO entries and drop_cnt=2 (macro on); rst_n pulsed mid-queue -> FIFO empty and all outputs 0.
